// File: rtl/ac_gain_pkg.sv
// -----------------------------------------------------------------------------
// ac_gain_pkg
// Shared definitions for the AC gain monitor: controller state encoding,
// Q-format fraction width and the saturating magnitude helper used by the
// peak trackers.
// No ports (package).
// -----------------------------------------------------------------------------
package ac_gain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Fractional bits of the gain result (unsigned Q(GW-8).8).
    localparam int FRAC_BITS = 8;

    // Working width of abs_sat; callers sign-extend into it and truncate the
    // result back to their own W-1 bits.
    localparam int ABS_W = 32;

    // |x| clamped to 2^(w-1)-1, so the most negative w-bit code maps onto the
    // largest positive magnitude instead of wrapping.
    function automatic logic [ABS_W-2:0] abs_sat(input logic signed [ABS_W-1:0] x,
                                                 input int                      w);
        logic [ABS_W-1:0] mag;
        logic [ABS_W-1:0] lim;
        lim = (ABS_W'(1) << (w - 1)) - ABS_W'(1);
        mag = x[ABS_W-1] ? ABS_W'(-x) : ABS_W'(x);
        if (mag > lim) begin
            mag = lim;
        end
        return (ABS_W-1)'(mag);
    endfunction

endpackage

// File: rtl/gain_divider.sv
// -----------------------------------------------------------------------------
// gain_divider
// Serial restoring divider, one quotient bit per clock, MSB first. A start
// pulse loads the operands and resolves the first quotient bit in the same
// edge, so a full division takes QW edges from start to the done pulse.
// Zero divisors and quotients that would not fit in QW bits are caught at
// start and reported one edge later as quotient = all ones with ovf = 1.
//
// Ports:
//   clk       in   1   clock
//   rst_n     in   1   synchronous active-low reset (control state only)
//   start     in   1   single-cycle request; samples num/den
//   num       in   NW  unsigned numerator
//   den       in   DW  unsigned denominator
//   done      out  1   one-cycle pulse when quotient/ovf are final
//   quotient  out  QW  floor(num/den), or all ones on ovf
//   ovf       out  1   divisor was zero or quotient exceeded QW bits
// -----------------------------------------------------------------------------
module gain_divider #(
    parameter int NW = 19,
    parameter int DW = 11,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] den,
    output logic          done,
    output logic [QW-1:0] quotient,
    output logic          ovf
);

    // Wide enough for den << QW, which is the largest value compared against.
    localparam int RW = ((NW > DW + QW) ? NW : DW + QW) + 1;
    localparam int CW = $clog2(QW + 1);

    logic          running;
    logic [CW-1:0] bits_left;
    logic [RW-1:0] rem_q;
    logic [RW-1:0] dsh_q;

    logic [RW-1:0] num_x;
    logic [RW-1:0] den_x;
    logic [RW-1:0] rem_cur;
    logic [RW-1:0] dsh_cur;
    logic [RW-1:0] rem_nxt;
    logic          pre_sat;
    logic          fits;

    assign num_x = RW'(num);
    assign den_x = RW'(den);

    // A quotient of 2^QW or more means num >= den << QW.
    assign pre_sat = (den == '0) || (num_x >= (den_x << QW));

    // The start cycle works on the fresh operands; later cycles on the
    // running remainder and the right-shifting divisor.
    assign rem_cur = start ? num_x : rem_q;
    assign dsh_cur = start ? (den_x << (QW - 1)) : dsh_q;
    assign fits    = (rem_cur >= dsh_cur);
    assign rem_nxt = fits ? (rem_cur - dsh_cur) : rem_cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running   <= 1'b0;
            bits_left <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                running   <= !pre_sat;
                bits_left <= CW'(QW - 1);
                done      <= pre_sat;
            end else if (running) begin
                bits_left <= bits_left - CW'(1);
                if (bits_left == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            ovf      <= pre_sat;
            quotient <= pre_sat ? '1 : QW'(fits);
            rem_q    <= rem_nxt;
            dsh_q    <= dsh_cur >> 1;
        end else if (running) begin
            quotient <= {quotient[QW-2:0], fits};
            rem_q    <= rem_nxt;
            dsh_q    <= dsh_q >> 1;
        end
    end

endmodule

// File: rtl/ac_gain_monitor.sv
// -----------------------------------------------------------------------------
// ac_gain_monitor
// Measures the small-signal gain |Out|/|In| of the feedback amplifier from
// paired digitised samples. Over a window of 2^WIN_LOG2 accepted pairs it
// tracks the peak magnitude of each channel, then divides out_peak*256 by
// in_peak to give an unsigned Q(GW-8).8 gain.
//
// Ports:
//   clk       in   1     clock
//   rst_n     in   1     synchronous active-low reset
//   start     in   1     begin a window (only honoured while idle)
//   s_valid   in   1     sample pair valid
//   s_ready   out  1     sample pair accepted on s_valid && s_ready
//   s_in      in   W     signed sample of the amplifier input node
//   s_out     in   W     signed sample of the amplifier output node
//   busy      out  1     any state other than IDLE
//   g_valid   out  1     result valid
//   g_ready   in   1     result consumed on g_valid && g_ready
//   gain      out  GW    measured gain, Q(GW-8).8
//   sat       out  1     gain saturated (zero In peak or overflow)
//   in_peak   out  W-1   peak |s_in| of the last completed window
//   out_peak  out  W-1   peak |s_out| of the last completed window
// -----------------------------------------------------------------------------
module ac_gain_monitor
    import ac_gain_pkg::*;
#(
    parameter int W        = 12,
    parameter int WIN_LOG2 = 10,
    parameter int GW       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [W-1:0] s_in,
    input  logic signed [W-1:0] s_out,
    output logic                busy,
    output logic                g_valid,
    input  logic                g_ready,
    output logic [GW-1:0]       gain,
    output logic                sat,
    output logic [W-2:0]        in_peak,
    output logic [W-2:0]        out_peak
);

    localparam int PW = W - 1;
    localparam int NW = PW + FRAC_BITS;

    state_t              state;
    state_t              state_nxt;

    logic                accept;
    logic                last_pair;
    logic [WIN_LOG2-1:0] cnt;
    logic [PW-1:0]       in_pk;
    logic [PW-1:0]       out_pk;
    logic [PW-1:0]       in_mag;
    logic [PW-1:0]       out_mag;

    logic                div_kick;
    logic                div_done;
    logic                div_ovf;
    logic [GW-1:0]       div_q;

    // s_ready is a registered decode of ACQ, so an accept implies ACQ.
    assign accept    = s_valid && s_ready;
    assign last_pair = &cnt;

    assign in_mag  = PW'(abs_sat(ABS_W'(s_in),  W));
    assign out_mag = PW'(abs_sat(ABS_W'(s_out), W));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)               state_nxt = ACQ;
            ACQ:     if (accept && last_pair) state_nxt = DIV;
            DIV:     if (div_done)            state_nxt = DONE;
            DONE:    if (g_valid && g_ready)  state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so that they
    // line up exactly with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            g_valid  <= 1'b0;
            div_kick <= 1'b0;
        end else begin
            state    <= state_nxt;
            s_ready  <= (state_nxt == ACQ);
            busy     <= (state_nxt != IDLE);
            g_valid  <= (state_nxt == DONE);
            // One-cycle launch in the first DIV cycle, once the peaks
            // already include the final pair.
            div_kick <= (state == ACQ) && (state_nxt == DIV);
        end
    end

    // ---- acquisition: window counter and peak trackers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            in_pk  <= '0;
            out_pk <= '0;
        end else if ((state == IDLE) && start) begin
            cnt    <= '0;
            in_pk  <= '0;
            out_pk <= '0;
        end else if (accept) begin
            cnt <= cnt + WIN_LOG2'(1);
            if (in_mag > in_pk) begin
                in_pk <= in_mag;
            end
            if (out_mag > out_pk) begin
                out_pk <= out_mag;
            end
        end
    end

    // ---- division: (out_peak << 8) / in_peak ----
    gain_divider #(
        .NW (NW),
        .DW (PW),
        .QW (GW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_kick),
        .num      ({out_pk, {FRAC_BITS{1'b0}}}),
        .den      (in_pk),
        .done     (div_done),
        .quotient (div_q),
        .ovf      (div_ovf)
    );

    // ---- result registers: held from one completed division to the next ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gain     <= '0;
            sat      <= 1'b0;
            in_peak  <= '0;
            out_peak <= '0;
        end else if ((state == DIV) && div_done) begin
            gain     <= div_q;
            sat      <= div_ovf;
            in_peak  <= in_pk;
            out_peak <= out_pk;
        end
    end

endmodule

// File: tb/tb_ac_gain_monitor.sv
// -----------------------------------------------------------------------------
// tb_ac_gain_monitor
// Self-checking bench for ac_gain_monitor with W=12, WIN_LOG2=4, GW=16.
// Table-driven windows with hand-derived expectations, hand-written flow
// control and reset sequences, and random windows checked against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_ac_gain_monitor;

    localparam int W        = 12;
    localparam int WIN_LOG2 = 4;
    localparam int GW       = 16;
    localparam int NPAIR    = 1 << WIN_LOG2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                s_valid;
    logic                s_ready;
    logic signed [W-1:0] s_in;
    logic signed [W-1:0] s_out;
    logic                busy;
    logic                g_valid;
    logic                g_ready;
    logic [GW-1:0]       gain;
    logic                sat;
    logic [W-2:0]        in_peak;
    logic [W-2:0]        out_peak;

    int nvec = 0;
    int nerr = 0;

    logic signed [W-1:0] win_in  [NPAIR];
    logic signed [W-1:0] win_out [NPAIR];

    int r_inpk, r_outpk, r_gain, r_sat, r_lat;

    typedef struct {
        int in_a;
        int out_a;
        int clamp;
        int e_inpk;
        int e_outpk;
        int e_gain;
        int e_sat;
        int e_lat;
    } vec_t;

    vec_t vt[11];

    ac_gain_monitor #(
        .W        (W),
        .WIN_LOG2 (WIN_LOG2),
        .GW       (GW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_in     (s_in),
        .s_out    (s_out),
        .busy     (busy),
        .g_valid  (g_valid),
        .g_ready  (g_ready),
        .gain     (gain),
        .sat      (sat),
        .in_peak  (in_peak),
        .out_peak (out_peak)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "bench did not complete");
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: magnitude clamped to the 11-bit unsigned range.
    function automatic int ref_mag(input int v);
        int m;
        m = (v < 0) ? -v : v;
        if (m > 2047) m = 2047;
        return m;
    endfunction

    task automatic send_pair(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                             input int gap);
        int ok;
        int got;
        got = 0;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_in    = a;
        s_out   = b;
        for (int k = 0; k < 50; k++) begin
            ok = int'(s_ready);
            tick();
            if (ok != 0) begin
                got = 1;
                break;
            end
        end
        s_valid = 1'b0;
        if (got == 0) check("accept_timeout", got, 1);
    endtask

    // Start a window, feed win_in/win_out, wait for g_valid and capture.
    task automatic run_window(input int gapmode);
        int gap;
        int got;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("s_ready_after_start", int'(s_ready), 1);
        for (int i = 0; i < NPAIR; i++) begin
            gap = (gapmode == 1) ? 1 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
            send_pair(win_in[i], win_out[i], gap);
        end
        check("s_ready_after_last", int'(s_ready), 0);
        r_lat = 0;
        got   = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            r_lat++;
            if (g_valid) begin
                got = 1;
                break;
            end
        end
        check("g_valid_seen", got, 1);
        r_inpk  = int'(in_peak);
        r_outpk = int'(out_peak);
        r_gain  = int'(gain);
        r_sat   = int'(sat);
    endtask

    task automatic handshake();
        g_ready = 1'b1;
        tick();
        g_ready = 1'b0;
        check("g_valid_after_hs", int'(g_valid), 0);
        check("busy_after_hs", int'(busy), 0);
    endtask

    task automatic fill_square(input int in_a, input int out_a);
        for (int i = 0; i < NPAIR; i++) begin
            win_in[i]  = W'((i % 2 == 0) ? in_a : -in_a);
            win_out[i] = W'((i % 2 == 0) ? out_a : -out_a);
        end
    endtask

    task automatic reset_pulse_check();
        rst_n = 1'b0;
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_g_valid", int'(g_valid), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_gain", int'(gain), 0);
        check("rst_in_peak", int'(in_peak), 0);
        check("rst_out_peak", int'(out_peak), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int lim_i, lim_o, vi, vo, epi, epo, eq, es, hold;

        rst_n   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        g_ready = 1'b0;
        s_in    = '0;
        s_out   = '0;
        repeat (3) tick();
        check("por_busy", int'(busy), 0);
        check("por_s_ready", int'(s_ready), 0);
        check("por_g_valid", int'(g_valid), 0);
        check("por_gain", int'(gain), 0);
        check("por_sat", int'(sat), 0);
        check("por_in_peak", int'(in_peak), 0);
        check("por_out_peak", int'(out_peak), 0);
        rst_n = 1'b1;
        tick();

        // in_a, out_a, clamp, in_peak, out_peak, gain, sat, latency
        vt[0]  = '{100,  400,  0, 100,  400,  'h0400, 0, 17};
        vt[1]  = '{300,  100,  0, 300,  100,  'h0055, 0, 17};
        vt[2]  = '{0,    500,  0, 0,    500,  'hFFFF, 1, 2};
        vt[3]  = '{1,    2047, 0, 1,    2047, 'hFFFF, 1, 2};
        vt[4]  = '{0,    0,    1, 2047, 0,    'h0000, 0, 17};
        vt[5]  = '{255,  255,  0, 255,  255,  'h0100, 0, 17};
        vt[6]  = '{1,    255,  0, 1,    255,  'hFF00, 0, 17};
        vt[7]  = '{1,    256,  0, 1,    256,  'hFFFF, 1, 2};
        vt[8]  = '{7,    2047, 0, 7,    2047, 'hFFFF, 1, 2};
        vt[9]  = '{8,    2047, 0, 8,    2047, 'hFFE0, 0, 17};
        vt[10] = '{2047, 2047, 0, 2047, 2047, 'h0100, 0, 17};

        for (int v = 0; v < 11; v++) begin
            fill_square(vt[v].in_a, vt[v].out_a);
            if (vt[v].clamp != 0) win_in[3] = W'(-2048);
            run_window(0);
            check("tbl_in_peak", r_inpk, vt[v].e_inpk);
            check("tbl_out_peak", r_outpk, vt[v].e_outpk);
            check("tbl_gain", r_gain, vt[v].e_gain);
            check("tbl_sat", r_sat, vt[v].e_sat);
            check("tbl_latency", r_lat, vt[v].e_lat);
            handshake();
            tick();
        end

        // Flow control: s_valid every other cycle, then a stalled consumer.
        fill_square(100, 400);
        run_window(1);
        check("fc_gain", r_gain, 'h0400);
        check("fc_latency", r_lat, 17);
        for (int k = 0; k < 10; k++) begin
            start = (k % 2 == 1);
            tick();
            check("fc_hold_g_valid", int'(g_valid), 1);
            check("fc_hold_gain", int'(gain), 'h0400);
            check("fc_hold_out_peak", int'(out_peak), 400);
        end
        start   = 1'b1;
        g_ready = 1'b1;
        tick();
        start   = 1'b0;
        g_ready = 1'b0;
        check("fc_start_at_hs_busy", int'(busy), 0);
        tick();
        check("fc_still_idle", int'(busy), 0);
        check("fc_result_kept", int'(gain), 'h0400);

        // Reset after accept #7.
        fill_square(300, 100);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) send_pair(win_in[i], win_out[i], 0);
        reset_pulse_check();
        tick();
        run_window(0);
        check("post_acq_rst_gain", r_gain, 'h0055);
        check("post_acq_rst_in_peak", r_inpk, 300);
        handshake();

        // Reset during division.
        fill_square(100, 400);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NPAIR; i++) send_pair(win_in[i], win_out[i], 0);
        repeat (5) tick();
        check("mid_div_busy", int'(busy), 1);
        reset_pulse_check();
        tick();
        run_window(0);
        check("post_div_rst_gain", r_gain, 'h0400);
        check("post_div_rst_sat", r_sat, 0);
        check("post_div_rst_latency", r_lat, 17);
        handshake();

        // Random windows against the reference model.
        for (int w = 0; w < 12; w++) begin
            lim_i = int'($urandom_range(0, 2048));
            lim_o = int'($urandom_range(0, 2048));
            epi   = 0;
            epo   = 0;
            for (int i = 0; i < NPAIR; i++) begin
                vi = int'($urandom_range(0, 2 * lim_i)) - lim_i;
                vo = int'($urandom_range(0, 2 * lim_o)) - lim_o;
                if (vi > 2047) vi = 2047;
                if (vo > 2047) vo = 2047;
                win_in[i]  = W'(vi);
                win_out[i] = W'(vo);
                if (ref_mag(vi) > epi) epi = ref_mag(vi);
                if (ref_mag(vo) > epo) epo = ref_mag(vo);
            end
            if (epi == 0) begin
                es = 1;
                eq = 65535;
            end else begin
                eq = (epo * 256) / epi;
                es = (eq > 65535) ? 1 : 0;
                if (es != 0) eq = 65535;
            end
            run_window(2);
            check("rnd_in_peak", r_inpk, epi);
            check("rnd_out_peak", r_outpk, epo);
            check("rnd_gain", r_gain, eq);
            check("rnd_sat", r_sat, es);
            check("rnd_latency", r_lat, (es != 0) ? 2 : 17);
            hold = int'($urandom_range(0, 3));
            for (int k = 0; k < hold; k++) begin
                tick();
                check("rnd_hold_g_valid", int'(g_valid), 1);
            end
            handshake();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ac_gain_monitor.md
# ac_gain_monitor

Digital gain-measurement stage downstream of the BJT feedback amplifier. It consumes paired, digitised samples of the amplifier input node (In) and output node (Out) and tracks the peak magnitude of each over a programmable window. It then computes the small-signal gain |Out|/|In| as an unsigned Q8.8 value with a serial divider. The block is the hardware counterpart of the bench's `Gain = abs(Out.v/In.v)` equation and feeds the calibration/reporting logic.

## Interface
Parameters:
- `W`, 12: signed sample width of both input channels.
- `WIN_LOG2`, 10: log2 of samples per measurement window; legal range 1..16.
- `GW`, 16: gain output width, unsigned Q(GW-8).8. `GW` must be greater than 8.

Ports:
- `clk`  in  1: sole clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1: synchronous active-low reset.
- `start`  in  1: single-cycle request to begin a window; honoured only in IDLE.
- `s_valid`  in  1: sample pair valid.
- `s_ready`  out  1: sample pair accepted when `s_valid && s_ready`.
- `s_in`  in  W: signed sample of the In node.
- `s_out`  in  W: signed sample of the Out node.
- `busy`  out  1: high in any state other than IDLE.
- `g_valid`  out  1: result valid.
- `g_ready`  in  1: result consumed when `g_valid && g_ready`.
- `gain`  out  GW: measured gain, Q(GW-8).8.
- `sat`  out  1: result saturated, either because the In peak was 0 or because of overflow.
- `in_peak`  out  W-1: peak |s_in| of the last window.
- `out_peak`  out  W-1: peak |s_out| of the last window.

## Operation
The block is a state machine with four states: IDLE, ACQ, DIV and DONE.

- **IDLE**
  - `start` moves the block to ACQ.
  - Entering ACQ clears both peak registers and the sample counter.
- **ACQ**
  - `s_ready` is 1 only in this state.
  - On each accepted pair, take the magnitude of each channel. Magnitude is absolute value saturated to 2^(W-1)-1, so -2^(W-1) maps to 2^(W-1)-1.
  - Each peak register updates when the new magnitude is strictly greater than the stored value.
  - The counter increments per accepted pair only. Cycles with `s_valid` low neither count nor update the peaks.
  - On the 2^WIN_LOG2-th accepted pair the block goes to DIV. The peaks include that final pair.
- **DIV**
  - Numerator N = out_peak << 8; denominator D = in_peak.
  - If D == 0: `gain` = all ones, `sat` = 1, go to DONE after 1 cycle.
  - Else if out_peak >= D << (GW-8) (overflow): `gain` = all ones, `sat` = 1, go to DONE after 1 cycle.
  - Else run a restoring division producing one quotient bit per cycle, MSB first, over GW cycles. The remainder is truncated (floor). `sat` = 0. Then go to DONE.
- **DONE**
  - `g_valid` = 1; `gain`, `sat`, `in_peak` and `out_peak` are stable.
  - On `g_valid && g_ready` the block returns to IDLE.
  - `gain`/`sat`/peaks keep their last values until the next DIV completes.
- `start` outside IDLE is ignored, including `start` in the same cycle as a DONE handshake.
- Reset, including reset mid-window or mid-division, aborts all activity. Reset values: state IDLE; `s_ready`, `busy`, `g_valid` and `sat` 0; `gain`, `in_peak` and `out_peak` 0; counter 0.

## Timing
- `start` sampled high in IDLE at edge t: `busy` and `s_ready` are 1 from t+1.
- Final pair accepted at edge a: `s_ready` is 0 from a+1.
- Normal division: `g_valid` rises at edge a+1+GW (a+17 for GW=16).
- Zero-denominator or overflow path: `g_valid` rises at edge a+2.
- With `g_ready` held high, `g_valid` lasts 1 cycle and the block is IDLE the next cycle. Back-to-back windows are therefore separated by at least 2 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `ac_gain_pkg` holds:
  - the state enum (IDLE/ACQ/DIV/DONE);
  - `FRAC_BITS` = 8;
  - the function `abs_sat(signed [W-1:0])` returning W-1 bits.
- Sub-module `gain_divider`: serial restoring divider.
  - Inputs: `start`, numerator, denominator.
  - Outputs: `done`, `quotient`, `ovf`.
  - The zero/overflow pre-check lives inside it.
- Top level: FSM, peak trackers, window counter.

## Test plan
All scenarios use `WIN_LOG2`=4, `W`=12, `GW`=16.
- **Nominal gain:** 16 pairs of a square wave, s_in = ±100 and s_out = ±400 -> `in_peak`=100, `out_peak`=400, `gain`=0x0400, `sat`=0, `g_valid` 17 cycles after the last accept.
- **Fractional gain:** s_in peak 300, s_out peak 100 -> `gain`=0x0055 (floor of 85.33), `sat`=0.
- **Zero and overflow:**
  - All s_in = 0 -> `gain`=0xFFFF, `sat`=1, `g_valid` 2 cycles after the last accept.
  - s_in peak 1 with s_out peak 2047 -> 0x07FF00 does not fit in 16 bits -> 0xFFFF, `sat`=1.
- **Most-negative clamp:** s_in = -2048 once, all other samples 0 -> `in_peak`=2047.
- **Flow control:** `s_valid` toggling every other cycle still needs exactly 16 accepts. With `g_ready` held low for 10 cycles, `g_valid`/`gain` stay stable and `start` is ignored.
- **Reset mid-operation:** `rst_n` low for 1 cycle after accept #7, and again mid-DIV -> next cycle IDLE with all outputs 0. A new `start` then produces a correct result from a full 16-pair window.
